// File: rtl/pwm_measure.sv
// Recovers duty (high cycles) and period of a sampled PWM waveform, one result per period,
// and flags stuck-high, stuck-low and off-nominal periods.
module pwm_measure #(
    parameter int unsigned PWM_INTERVAL = 1200,
    parameter int unsigned TOLERANCE    = 12,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned TIMEOUT      = 2 * PWM_INTERVAL,
    parameter int unsigned CW           = $clog2(TIMEOUT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pwm_in,
    output logic [CW-1:0] duty_value,
    output logic [CW-1:0] period_value,
    output logic          valid,
    output logic          period_error,
    output logic          stuck_high,
    output logic          stuck_low
);

    localparam logic [CW-1:0] TimeoutCnt  = CW'(TIMEOUT);
    localparam logic [CW-1:0] IntervalCnt = CW'(PWM_INTERVAL);
    localparam logic [CW-1:0] PeriodLo    = CW'(PWM_INTERVAL - TOLERANCE);
    localparam logic [CW-1:0] PeriodHi    = CW'(PWM_INTERVAL + TOLERANCE);

    typedef enum logic [0:0] {StIdle, StMeasure} state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_prev_q;
    logic                   s;
    logic                   rise;

    logic [CW-1:0] period_cnt_q, period_cnt_d;
    logic [CW-1:0] high_cnt_q, high_cnt_d;
    state_e        state_q, state_d;
    logic          timed_out_q, timed_out_d;

    logic [CW-1:0] duty_d, period_d;
    logic          valid_d, period_error_d, stuck_high_d, stuck_low_d;
    logic          do_publish, do_stuck, at_timeout;

    assign s          = sync_q[SYNC_STAGES-1];
    assign rise       = s & ~s_prev_q;
    assign at_timeout = (period_cnt_q == TimeoutCnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            s_prev_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            s_prev_q <= s;
        end
    end

    // Both counters saturate so a dead input cannot wrap back into a plausible period.
    always_comb begin
        period_cnt_d = period_cnt_q;
        high_cnt_d   = high_cnt_q;
        if (rise) begin
            period_cnt_d = CW'(1);
            high_cnt_d   = CW'(1);
        end else begin
            if (period_cnt_q != TimeoutCnt) begin
                period_cnt_d = period_cnt_q + CW'(1);
            end
            if (s && (high_cnt_q != TimeoutCnt)) begin
                high_cnt_d = high_cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        timed_out_d    = timed_out_q;
        duty_d         = duty_value;
        period_d       = period_value;
        valid_d        = 1'b0;
        period_error_d = period_error;
        stuck_high_d   = stuck_high;
        stuck_low_d    = stuck_low;
        do_publish     = 1'b0;
        do_stuck       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d = StMeasure;
                end else if (at_timeout && !timed_out_q) begin
                    do_stuck = 1'b1;
                end
            end
            StMeasure: begin
                if (rise) begin
                    do_publish = 1'b1;
                end else if (at_timeout) begin
                    state_d  = StIdle;
                    do_stuck = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (rise) begin
            timed_out_d = 1'b0;
        end

        // Publish uses the counts accumulated up to (not including) this rise.
        if (do_publish) begin
            duty_d         = high_cnt_q;
            period_d       = period_cnt_q;
            period_error_d = (period_cnt_q < PeriodLo) | (period_cnt_q > PeriodHi);
            stuck_high_d   = 1'b0;
            stuck_low_d    = 1'b0;
            valid_d        = 1'b1;
        end

        if (do_stuck) begin
            duty_d         = s ? IntervalCnt : '0;
            period_d       = IntervalCnt;
            period_error_d = 1'b0;
            stuck_high_d   = s;
            stuck_low_d    = ~s;
            valid_d        = 1'b1;
            timed_out_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            state_q      <= StIdle;
            timed_out_q  <= 1'b0;
            duty_value   <= '0;
            period_value <= '0;
            valid        <= 1'b0;
            period_error <= 1'b0;
            stuck_high   <= 1'b0;
            stuck_low    <= 1'b0;
        end else begin
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            state_q      <= state_d;
            timed_out_q  <= timed_out_d;
            duty_value   <= duty_d;
            period_value <= period_d;
            valid        <= valid_d;
            period_error <= period_error_d;
            stuck_high   <= stuck_high_d;
            stuck_low    <= stuck_low_d;
        end
    end

endmodule

// File: tb/tb_pwm_measure.sv
// Randomized bench for pwm_measure: a sample-level waveform model predicts every publish and
// all outputs are compared on every clock.
module tb_pwm_measure;

    localparam int unsigned PWM_INTERVAL = 1200;
    localparam int unsigned TOLERANCE    = 12;
    localparam int unsigned SYNC_STAGES  = 2;
    localparam int unsigned TIMEOUT      = 2 * PWM_INTERVAL;
    localparam int unsigned CW           = $clog2(TIMEOUT + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pwm_in = 1'b0;
    logic [CW-1:0] duty_value;
    logic [CW-1:0] period_value;
    logic          valid;
    logic          period_error;
    logic          stuck_high;
    logic          stuck_low;

    pwm_measure #(
        .PWM_INTERVAL(PWM_INTERVAL),
        .TOLERANCE   (TOLERANCE),
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT     (TIMEOUT),
        .CW          (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pwm_in      (pwm_in),
        .duty_value  (duty_value),
        .period_value(period_value),
        .valid       (valid),
        .period_error(period_error),
        .stuck_high  (stuck_high),
        .stuck_low   (stuck_low)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int duty;
        int period;
        bit err;
        bit sh;
        bit sl;
    } pub_t;

    pub_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    // Waveform model state, in units of input samples (sample k is taken by clock edge k).
    bit measuring = 0;
    bit armed     = 0;
    int last      = 0;
    int high      = 0;
    bit pv        = 0;

    int h_duty   = 0;
    int h_period = 0;
    bit h_err    = 0;
    bit h_sh     = 0;
    bit h_sl     = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic void push(int at, int d, int p, bit e, bit sh, bit sl);
        pub_t x;
        x.cyc = at;
        x.duty = d;
        x.period = p;
        x.err = e;
        x.sh = sh;
        x.sl = sl;
        q.push_back(x);
    endfunction

    task automatic step(input bit v, input bit r);
        int          k;
        int          p;
        bit          ev;
        pub_t        e;
        logic [63:0] obs;
        logic [63:0] expv;
        pwm_in = v;
        rst    = r;
        k      = cyc + 1;
        if (r) begin
            while (q.size() > 0 && q[q.size()-1].cyc >= k) void'(q.pop_back());
            h_duty = 0; h_period = 0; h_err = 0; h_sh = 0; h_sl = 0;
            measuring = 0;
            armed     = 1;
            last      = k + 1 - int'(SYNC_STAGES);
            high      = 0;
            pv        = 0;
        end else begin
            if (v && !pv) begin
                if (measuring) begin
                    p = k - last;
                    push(k + int'(SYNC_STAGES), high, p,
                         (p < int'(PWM_INTERVAL - TOLERANCE)) || (p > int'(PWM_INTERVAL + TOLERANCE)),
                         1'b0, 1'b0);
                end
                measuring = 1;
                armed     = 1;
                last      = k;
                high      = 1;
            end else begin
                high += int'(v);
                if (armed && (k - last == int'(TIMEOUT))) begin
                    push(k + int'(SYNC_STAGES), v ? int'(PWM_INTERVAL) : 0, int'(PWM_INTERVAL),
                         1'b0, v, !v);
                    measuring = 0;
                    armed     = 0;
                end
            end
            pv = v;
        end
        @(posedge clk);
        cyc++;
        #1;
        ev = 0;
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            h_duty = e.duty; h_period = e.period; h_err = e.err; h_sh = e.sh; h_sl = e.sl;
            ev = 1;
        end
        obs  = {36'd0, valid, duty_value, period_value, period_error, stuck_high, stuck_low};
        expv = {36'd0, ev, CW'(h_duty), CW'(h_period), h_err, h_sh, h_sl};
        check(r ? "reset_outputs" : "outputs", obs, expv);
    endtask

    task automatic hold(input bit v, input int n);
        for (int i = 0; i < n; i++) step(v, 1'b0);
    endtask

    task automatic period(input int h, input int p);
        hold(1'b1, h);
        hold(1'b0, p - h);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(pwm_in, 1'b1);
    endtask

    initial begin
        int p;
        int h;

        // Reset, then a dead-low input resolves through the idle timeout.
        do_reset(3);
        hold(1'b0, 2600);

        // Nominal 25% duty: the first edge after reset stays silent.
        do_reset(2);
        for (int i = 0; i < 5; i++) period(300, 1200);

        // Duty sweep in steps of 7 (every tenth step).
        for (int i = 1; i <= 171; i += 10) period(7 * i, 1200);

        // Stuck high after normal operation, then recovery.
        hold(1'b1, 3000);
        hold(1'b0, 900);
        for (int i = 0; i < 3; i++) period(300, 1200);

        // Tolerance boundaries.
        period(400, 1188);
        period(400, 1212);
        period(400, 1187);
        period(400, 1213);
        period(400, 1200);

        // One-cycle pulses and a rise landing exactly on the timeout.
        period(1, 1200);
        period(1, 1200);
        period(100, 2400);
        period(300, 1200);

        // Reset 600 cycles into a period.
        hold(1'b1, 300);
        hold(1'b0, 299);
        do_reset(1);
        hold(1'b0, 600);
        for (int i = 0; i < 3; i++) period(300, 1200);

        // Input high across reset.
        pwm_in = 1'b1;
        do_reset(3);
        hold(1'b1, 300);
        hold(1'b0, 900);
        for (int i = 0; i < 2; i++) period(500, 1200);

        // Randomized periods and duties around nominal.
        for (int i = 0; i < 8; i++) begin
            p = int'($urandom_range(1150, 1250));
            h = int'($urandom_range(1, p - 1));
            period(h, p);
        end

        // Final rise publishes the last random period, then drain.
        hold(1'b1, 5);
        hold(1'b0, 5);
        check("drain", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
